// File: rtl/main_control_fsm.sv
// Multicycle MIPS main controller: Moore decode of the state register plus a
// branch-qualified PC enable. The state register is reset asynchronously to INIT.
module main_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam int unsigned StateW = 4;
    localparam int unsigned OpW    = 6;

    localparam logic [OpW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OpW-1:0] OP_J     = 6'b000010;
    localparam logic [OpW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OpW-1:0] OP_BNE   = 6'b000101;
    localparam logic [OpW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OpW-1:0] OP_LW    = 6'b100011;
    localparam logic [OpW-1:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [StateW-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_BNE     = 4'd12,
        S_INIT    = 4'd15
    } state_e;

    typedef struct packed {
        logic       iord;
        logic       alu_src_a;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       done;
        logic       illegal;
    } ctrl_t;

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    // State register; reset forces INIT without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; unused encodings fall to the default arm.
    always_comb begin
        state_d = S_FETCH;
        ctrl    = '0;
        unique case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALU_ADD;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_BNE:       state_d = S_BNE;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d      = S_FETCH;
                        ctrl.illegal = 1'b1;
                        ctrl.done    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALU_ADD;
                state_d        = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.done       = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.done      = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.done      = 1'b1;
                state_d        = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALU_ADD;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
                state_d        = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = 2'b01;
                ctrl.done      = 1'b1;
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_src   = 2'b10;
                ctrl.pc_write = 1'b1;
                ctrl.done     = 1'b1;
                state_d       = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign IorD       = ctrl.iord;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign IRWrite    = ctrl.ir_write;
    assign MemWrite   = ctrl.mem_write;
    assign RegWrite   = ctrl.reg_write;
    assign RegDst     = ctrl.reg_dst;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign PCSrc      = ctrl.pc_src;
    assign ALUOp      = ctrl.alu_op;
    assign instr_done = ctrl.done;
    assign illegal_op = ctrl.illegal;
    assign state      = StateW'(state_q);

    // Branch qualification uses the live ALU zero flag in the branch cycle.
    assign pc_en = ctrl.pc_write
                 | ((state_q == S_BEQ) &  zero)
                 | ((state_q == S_BNE) & ~zero);

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: stimulus queues hand-computed output
// vectors, a monitor pops one per check point and compares the packed outputs.
module tb_main_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       IorD, ALUSrcA, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg;
    logic [1:0] ALUSrcB, PCSrc, ALUOp;
    logic       pc_en, instr_done, illegal_op;
    logic [3:0] state;

    main_control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .IorD       (IorD),
        .ALUSrcA    (ALUSrcA),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUOp      (ALUOp),
        .pc_en      (pc_en),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, IorD, ALUSrcA, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg,
    //  ALUSrcB, PCSrc, ALUOp, pc_en, instr_done, illegal_op}
    logic [19:0] act;
    assign act = {state, IorD, ALUSrcA, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg,
                  ALUSrcB, PCSrc, ALUOp, pc_en, instr_done, illegal_op};

    typedef struct {
        logic [19:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    event sample_ev;

    logic [19:0] e_init, e_fetch, e_dec, e_dec_ill, e_memadr, e_memrd, e_memwb, e_memwr;
    logic [19:0] e_exec, e_aluwb, e_addiex, e_addiwb, e_beq_t, e_beq_n, e_bne_t, e_bne_n, e_jump;

    task automatic push(input logic [19:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops at each falling edge, or immediately on sample_ev.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (act !== e.v) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", e.tag, act, e.v);
                end
            end
        end
    end

    initial begin
        //            st     IorD  SrcA  IRW   MemW  RegW  RDst  M2R   SrcB   PCSrc  ALUOp  pcen  done  ill
        e_init    = {4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        e_fetch   = {4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        e_dec     = {4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        e_dec_ill = {4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        e_memadr  = {4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        e_memrd   = {4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        e_memwb   = {4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        e_memwr   = {4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        e_exec    = {4'd6,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
        e_aluwb   = {4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        e_addiex  = {4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        e_addiwb  = {4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        e_beq_t   = {4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0};
        e_beq_n   = {4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0};
        e_bne_t   = {4'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0};
        e_bne_n   = {4'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0};
        e_jump    = {4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0};

        rst_n  = 1'b0;
        opcode = 6'b000000;
        zero   = 1'b0;

        // Held in reset across an edge, then released between edges.
        cycles(1);
        push(e_init, "reset_hold");
        cycles(1);
        rst_n = 1'b1;
        push(e_init, "init_after_release");
        cycles(1);

        // LW, with opcode scrambled after MEMADR to show it is ignored there.
        opcode = 6'b100011; zero = 1'b1;
        push(e_fetch, "lw_fetch"); push(e_dec, "lw_decode"); push(e_memadr, "lw_memadr");
        push(e_memrd, "lw_memrd"); push(e_memwb, "lw_memwb");
        cycles(3);
        opcode = 6'b111111;
        cycles(2);

        opcode = 6'b101011; zero = 1'b0;
        push(e_fetch, "sw_fetch"); push(e_dec, "sw_decode"); push(e_memadr, "sw_memadr");
        push(e_memwr, "sw_memwr");
        cycles(4);

        opcode = 6'b000000; zero = 1'b1;
        push(e_fetch, "r_fetch"); push(e_dec, "r_decode"); push(e_exec, "r_execute");
        push(e_aluwb, "r_aluwb");
        cycles(4);

        opcode = 6'b001000; zero = 1'b0;
        push(e_fetch, "addi_fetch"); push(e_dec, "addi_decode"); push(e_addiex, "addi_ex");
        push(e_addiwb, "addi_wb");
        cycles(4);

        opcode = 6'b000100; zero = 1'b1;
        push(e_fetch, "beq_t_fetch"); push(e_dec, "beq_t_decode"); push(e_beq_t, "beq_taken");
        cycles(3);

        opcode = 6'b000100; zero = 1'b0;
        push(e_fetch, "beq_n_fetch"); push(e_dec, "beq_n_decode"); push(e_beq_n, "beq_not_taken");
        cycles(3);

        opcode = 6'b000101; zero = 1'b0;
        push(e_fetch, "bne_t_fetch"); push(e_dec, "bne_t_decode"); push(e_bne_t, "bne_taken");
        cycles(3);

        opcode = 6'b000101; zero = 1'b1;
        push(e_fetch, "bne_n_fetch"); push(e_dec, "bne_n_decode"); push(e_bne_n, "bne_not_taken");
        cycles(3);

        opcode = 6'b000010; zero = 1'b0;
        push(e_fetch, "j_fetch"); push(e_dec, "j_decode"); push(e_jump, "j_jump");
        cycles(3);

        opcode = 6'b111111;
        push(e_fetch, "ill_fetch"); push(e_dec_ill, "ill_decode");
        cycles(2);

        opcode = 6'b000001;
        push(e_fetch, "ill2_fetch"); push(e_dec_ill, "ill2_decode");
        cycles(2);

        // SW interrupted by reset in MEMWR, asserted between clock edges.
        opcode = 6'b101011;
        push(e_fetch, "swr_fetch"); push(e_dec, "swr_decode"); push(e_memadr, "swr_memadr");
        cycles(3);
        push(e_memwr, "swr_memwr");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        push(e_init, "swr_async_reset");
        -> sample_ev;
        cycles(1);
        push(e_init, "swr_reset_hold");
        cycles(1);
        rst_n = 1'b1;
        push(e_init, "swr_release");
        cycles(1);

        opcode = 6'b000010; zero = 1'b1;
        push(e_fetch, "post_fetch"); push(e_dec, "post_decode"); push(e_jump, "post_jump");
        cycles(3);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
